// File: rtl/alu_exec_stage_pkg.sv
// rtl/alu_exec_stage_pkg.sv - shared ALU opcode encoding, flag indices and opcode helpers (honours ALU_EXEC_SHIFT_EN)
package alu_opcodes;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_ASR = 3'd7
    } alu_op_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

`ifdef ALU_EXEC_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    // Shift opcodes are only legal when the in-stage shifter is built.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_XOR) || SHIFT_EN;
    endfunction

    function automatic logic op_is_shift(input logic [2:0] op);
        return (op >= OP_SHL) && SHIFT_EN;
    endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// rtl/alu_exec_stage_if.sv - decode, ALU and writeback signal bundle of the execute stage
interface alu_exec_stage_if #(
    parameter int DATA_W = 8,
    parameter int RD_W   = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [RD_W-1:0]   in_rd;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_cout;
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [RD_W-1:0]   wb_rd;
    logic [3:0]        flags;
    logic              op_err;

    // Environment side: decode, the combinational ALU and writeback.
    modport master (
        output in_valid, in_op, in_a, in_b, in_rd, alu_result, alu_cout, wb_ready,
        input  in_ready, alu_op, alu_a, alu_b, wb_valid, wb_data, wb_rd, flags, op_err
    );

    // Execute stage side.
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_rd, alu_result, alu_cout, wb_ready,
        output in_ready, alu_op, alu_a, alu_b, wb_valid, wb_data, wb_rd, flags, op_err
    );
endinterface

// File: rtl/alu_exec_stage_flag_gen.sv
// rtl/alu_exec_stage_flag_gen.sv - combinational Z/N/C/V flag generation (shift cases under ALU_EXEC_SHIFT_EN)
module alu_flag_gen
    import alu_opcodes::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_result,
    input  logic              i_cout,
    output logic [3:0]        o_flags
);
    logic w_a7, w_b7, w_r7;

    assign w_a7 = i_a[DATA_W-1];
    assign w_b7 = i_b[DATA_W-1];
    assign w_r7 = i_result[DATA_W-1];

    // Z/N come from the result; C/V depend on the operation class.
    always_comb begin
        o_flags         = 4'b0000;
        o_flags[FLAG_Z] = (i_result == '0);
        o_flags[FLAG_N] = w_r7;
        case (i_op)
            OP_ADD: begin
                o_flags[FLAG_C] = i_cout;
                o_flags[FLAG_V] = ~(w_a7 ^ w_b7) & (w_a7 ^ w_r7);
            end
            OP_SUB: begin
                o_flags[FLAG_C] = i_cout;
                o_flags[FLAG_V] = (w_a7 ^ w_b7) & (w_a7 ^ w_r7);
            end
`ifdef ALU_EXEC_SHIFT_EN
            OP_SHL, OP_SHR, OP_ASR: begin
                o_flags[FLAG_C] = i_cout;
            end
`endif
            default: begin
                o_flags[FLAG_C] = 1'b0;
                o_flags[FLAG_V] = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute-stage sequencer around the 8-bit ALU; ALU_EXEC_SHIFT_EN adds in-stage shifts
module alu_exec_stage
    import alu_opcodes::*;
#(
    parameter int DATA_W = 8,
    parameter int RD_W   = 3
) (
    input  logic            clk,
    input  logic            rst,
    alu_exec_stage_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
`ifdef ALU_EXEC_SHIFT_EN
        S_SHIFT = 2'd3,
`endif
        S_DONE  = 2'd2
    } state_e;

    state_e            r_state;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [RD_W-1:0]   r_rd;
    logic              r_wb_valid;
    logic [DATA_W-1:0] r_wb_data;
    logic [3:0]        r_flags;
    logic              r_op_err;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_legal;
    logic [DATA_W-1:0] w_fg_result;
    logic              w_fg_cout;
    logic [3:0]        w_flags;

    // Ready depends only on state and the downstream ready, never on in_valid.
    assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.wb_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_legal    = op_is_legal(r_op);

`ifdef ALU_EXEC_SHIFT_EN
    logic [DATA_W-1:0] r_sh;
    logic [2:0]        r_cnt;
    logic              r_sh_c;
    logic [DATA_W-1:0] w_sh_next;
    logic              w_sh_c;

    // One bit of shift per cycle; a zero count leaves value and carry untouched.
    always_comb begin
        w_sh_next = r_sh;
        w_sh_c    = r_sh_c;
        if (r_cnt != 3'd0) begin
            case (r_op)
                OP_SHL: begin
                    w_sh_next = {r_sh[DATA_W-2:0], 1'b0};
                    w_sh_c    = r_sh[DATA_W-1];
                end
                OP_SHR: begin
                    w_sh_next = {1'b0, r_sh[DATA_W-1:1]};
                    w_sh_c    = r_sh[0];
                end
                default: begin
                    w_sh_next = {r_sh[DATA_W-1], r_sh[DATA_W-1:1]};
                    w_sh_c    = r_sh[0];
                end
            endcase
        end
    end

    assign w_fg_result = (r_state == S_SHIFT) ? w_sh_next : bus.alu_result;
    assign w_fg_cout   = (r_state == S_SHIFT) ? w_sh_c    : bus.alu_cout;
`else
    assign w_fg_result = bus.alu_result;
    assign w_fg_cout   = bus.alu_cout;
`endif

    alu_flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_result (w_fg_result),
        .i_cout   (w_fg_cout),
        .o_flags  (w_flags)
    );

    // Sequencer: accept op, execute (or shift), hold the writeback beat until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= 3'd0;
            r_a        <= '0;
            r_b        <= '0;
            r_rd       <= '0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_flags    <= 4'b0000;
            r_op_err   <= 1'b0;
`ifdef ALU_EXEC_SHIFT_EN
            r_sh       <= '0;
            r_cnt      <= 3'd0;
            r_sh_c     <= 1'b0;
`endif
        end else begin
            r_op_err <= 1'b0;
            case (r_state)
                S_IDLE: r_state <= S_IDLE;
                S_EXEC: begin
                    r_wb_data  <= w_legal ? bus.alu_result : r_a;
                    if (w_legal) begin
                        r_flags <= w_flags;
                    end
                    r_op_err   <= !w_legal;
                    r_wb_valid <= 1'b1;
                    r_state    <= S_DONE;
                end
`ifdef ALU_EXEC_SHIFT_EN
                S_SHIFT: begin
                    if (r_cnt <= 3'd1) begin
                        r_wb_data  <= w_sh_next;
                        r_flags    <= w_flags;
                        r_wb_valid <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_sh   <= w_sh_next;
                        r_sh_c <= w_sh_c;
                        r_cnt  <= r_cnt - 3'd1;
                    end
                end
`endif
                S_DONE: begin
                    if (bus.wb_ready) begin
                        r_wb_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // An accepted op overrides the IDLE/DONE next-state chosen above.
            if (w_accept) begin
                r_op    <= bus.in_op;
                r_a     <= bus.in_a;
                r_b     <= bus.in_b;
                r_rd    <= bus.in_rd;
                r_state <= S_EXEC;
`ifdef ALU_EXEC_SHIFT_EN
                r_sh    <= bus.in_a;
                r_cnt   <= bus.in_b[2:0];
                r_sh_c  <= 1'b0;
                if (op_is_shift(bus.in_op)) begin
                    r_state <= S_SHIFT;
                end
`endif
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.alu_op   = r_op;
    assign bus.alu_a    = r_a;
    assign bus.alu_b    = r_b;
    assign bus.wb_valid = r_wb_valid;
    assign bus.wb_data  = r_wb_data;
    assign bus.wb_rd    = r_rd;
    assign bus.flags    = r_flags;
    assign bus.op_err   = r_op_err;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed self-checking bench for alu_exec_stage (ALU_EXEC_SHIFT_EN aware)
module tb_alu_exec_stage;
    import alu_opcodes::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_exec_stage_if bus ();

    alu_exec_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Combinational ALU in front of the stage.
    logic [8:0] m_sum;
    always_comb begin
        case (bus.alu_op)
            OP_ADD:  m_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            OP_SUB:  m_sum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            OP_AND:  m_sum = {1'b0, bus.alu_a & bus.alu_b};
            OP_OR:   m_sum = {1'b0, bus.alu_a | bus.alu_b};
            OP_XOR:  m_sum = {1'b0, bus.alu_a ^ bus.alu_b};
            default: m_sum = 9'h000;
        endcase
    end
    assign bus.alu_result = m_sum[7:0];
    assign bus.alu_cout   = m_sum[8];

    // Drives one op from IDLE and returns the beat observed; wb_ready must be 1.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] rd, output logic [7:0] data, output logic [3:0] fl,
                          output logic [2:0] rdo, output logic err, output int lat);
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_rd    = rd;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        err = 1'b0;
        while (!bus.wb_valid && lat < 50) begin
            err = err | bus.op_err;
            @(posedge clk); #1;
            lat++;
        end
        err  = err | bus.op_err;
        data = bus.wb_data;
        fl   = bus.flags;
        rdo  = bus.wb_rd;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        total++;
        if ({bus.wb_valid, bus.op_err, bus.flags, bus.wb_data, bus.wb_rd, bus.alu_op, bus.alu_a, bus.alu_b} !== 37'h0) begin
            bad++; $display("FAIL reset_outputs got wb_valid=%b op_err=%b flags=%b wb_data=%h wb_rd=%0d alu=%0d/%h/%h exp all zero",
                            bus.wb_valid, bus.op_err, bus.flags, bus.wb_data, bus.wb_rd, bus.alu_op, bus.alu_a, bus.alu_b);
        end
    endtask

    task automatic test_add();
        logic [7:0] d; logic [3:0] f; logic [2:0] r; logic e; int l;
        run_op(OP_ADD, 8'h7F, 8'h01, 3'd5, d, f, r, e, l);
        total++; if (l !== 2)       begin bad++; $display("FAIL add_latency got=%0d exp=2", l); end
        total++; if (d !== 8'h80)   begin bad++; $display("FAIL add_data got=%h exp=80", d); end
        total++; if (f !== 4'b0101) begin bad++; $display("FAIL add_flags got=%b exp=0101", f); end
        total++; if (r !== 3'd5)    begin bad++; $display("FAIL add_rd got=%0d exp=5", r); end
        total++; if (e !== 1'b0)    begin bad++; $display("FAIL add_op_err got=%b exp=0", e); end
    endtask

    task automatic test_sub();
        logic [7:0] d; logic [3:0] f; logic [2:0] r; logic e; int l;
        run_op(OP_SUB, 8'h05, 8'h05, 3'd1, d, f, r, e, l);
        total++; if (d !== 8'h00)   begin bad++; $display("FAIL sub_zero_data got=%h exp=00", d); end
        total++; if (f !== 4'b1000) begin bad++; $display("FAIL sub_zero_flags got=%b exp=1000", f); end
        run_op(OP_SUB, 8'h80, 8'h01, 3'd2, d, f, r, e, l);
        total++; if (d !== 8'h7F)   begin bad++; $display("FAIL sub_ovf_data got=%h exp=7f", d); end
        total++; if (f !== 4'b0001) begin bad++; $display("FAIL sub_ovf_flags got=%b exp=0001", f); end
    endtask

    task automatic test_xor_stall();
        bus.wb_ready = 1'b0;
        bus.in_op    = OP_XOR;
        bus.in_a     = 8'hF0;
        bus.in_b     = 8'hFF;
        bus.in_rd    = 3'd3;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        // A different op stays offered; it must be ignored while in_ready is low.
        bus.in_op    = OP_ADD;
        bus.in_a     = 8'h11;
        bus.in_b     = 8'h22;
        bus.in_rd    = 3'd7;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.wb_valid !== 1'b1 || bus.wb_data !== 8'h0F || bus.wb_rd !== 3'd3 || bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL xor_stall_%0d got valid=%b data=%h rd=%0d in_ready=%b exp valid=1 data=0f rd=3 in_ready=0",
                         i, bus.wb_valid, bus.wb_data, bus.wb_rd, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        total++; if (bus.flags !== 4'b0000) begin bad++; $display("FAIL xor_flags got=%b exp=0000", bus.flags); end
        total++; if (bus.alu_a !== 8'hF0)   begin bad++; $display("FAIL xor_ignored_input got alu_a=%h exp=f0", bus.alu_a); end
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL xor_ready_follow got=%b exp=1", bus.in_ready); end
        @(posedge clk); #1;
        total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL xor_release got wb_valid=%b exp=0", bus.wb_valid); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [4];
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic [7:0] ex [4];
        int na, nb, last, cyc;
        logic acc;
        ops[0] = OP_ADD; va[0] = 8'h01; vb[0] = 8'h02; ex[0] = 8'h03;
        ops[1] = OP_SUB; va[1] = 8'h10; vb[1] = 8'h03; ex[1] = 8'h0D;
        ops[2] = OP_AND; va[2] = 8'h3C; vb[2] = 8'h0F; ex[2] = 8'h0C;
        ops[3] = OP_OR;  va[3] = 8'h50; vb[3] = 8'h05; ex[3] = 8'h55;
        na = 0; nb = 0; last = 0; cyc = 0;
        bus.wb_ready = 1'b1;
        bus.in_op = ops[0]; bus.in_a = va[0]; bus.in_b = vb[0]; bus.in_rd = 3'd1;
        bus.in_valid = 1'b1;
        while (nb < 4 && cyc < 40) begin
            acc = bus.in_valid && bus.in_ready;
            if (bus.wb_valid && bus.wb_ready) begin
                total++;
                if (bus.wb_data !== ex[nb] || bus.wb_rd !== 3'(nb + 1)) begin
                    bad++;
                    $display("FAIL b2b_beat_%0d got data=%h rd=%0d exp data=%h rd=%0d", nb, bus.wb_data, bus.wb_rd, ex[nb], nb + 1);
                end
                nb++;
            end
            if (acc) begin
                if (na > 0) begin
                    total++;
                    if (cyc - last !== 2) begin bad++; $display("FAIL b2b_gap_%0d got=%0d exp=2", na, cyc - last); end
                end
                last = cyc;
                na++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (na < 4) begin
                    bus.in_op = ops[na]; bus.in_a = va[na]; bus.in_b = vb[na]; bus.in_rd = 3'(na + 1);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
        total++; if (na !== 4) begin bad++; $display("FAIL b2b_accepts got=%0d exp=4", na); end
        total++; if (nb !== 4) begin bad++; $display("FAIL b2b_beats got=%0d exp=4", nb); end
    endtask

    task automatic test_reset_exec();
        logic [7:0] d; logic [3:0] f; logic [2:0] r; logic e; int l;
        logic seen;
        run_op(OP_ADD, 8'h7F, 8'h01, 3'd4, d, f, r, e, l);
        total++; if (f !== 4'b0101) begin bad++; $display("FAIL rstx_pre_flags got=%b exp=0101", f); end
        bus.in_op = OP_ADD; bus.in_a = 8'h01; bus.in_b = 8'h01; bus.in_rd = 3'd6;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (bus.flags !== 4'b0000) begin bad++; $display("FAIL rstx_flags got=%b exp=0000", bus.flags); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstx_in_ready got=%b exp=1", bus.in_ready); end
        seen = bus.wb_valid;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen = seen | bus.wb_valid;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstx_no_beat got wb_valid_seen=%b exp=0", seen); end
    endtask

    task automatic test_shift_ops();
        logic [7:0] d; logic [3:0] f; logic [2:0] r; logic e; int l;
        run_op(OP_ADD, 8'h7F, 8'h01, 3'd0, d, f, r, e, l);
        run_op(3'd5, 8'h81, 8'h01, 3'd6, d, f, r, e, l);
`ifdef ALU_EXEC_SHIFT_EN
        total++; if (d !== 8'h02)   begin bad++; $display("FAIL op5_data got=%h exp=02", d); end
        total++; if (f !== 4'b0010) begin bad++; $display("FAIL op5_flags got=%b exp=0010", f); end
        total++; if (e !== 1'b0)    begin bad++; $display("FAIL op5_op_err got=%b exp=0", e); end
`else
        total++; if (d !== 8'h81)   begin bad++; $display("FAIL op5_data got=%h exp=81", d); end
        total++; if (f !== 4'b0101) begin bad++; $display("FAIL op5_flags got=%b exp=0101", f); end
        total++; if (e !== 1'b1)    begin bad++; $display("FAIL op5_op_err got=%b exp=1", e); end
`endif
        total++; if (l !== 2)            begin bad++; $display("FAIL op5_latency got=%0d exp=2", l); end
        total++; if (bus.op_err !== 1'b0) begin bad++; $display("FAIL op5_err_pulse_width got=%b exp=0", bus.op_err); end
        run_op(3'd7, 8'h81, 8'h02, 3'd2, d, f, r, e, l);
`ifdef ALU_EXEC_SHIFT_EN
        total++; if (d !== 8'hE0)   begin bad++; $display("FAIL op7_data got=%h exp=e0", d); end
        total++; if (f !== 4'b0100) begin bad++; $display("FAIL op7_flags got=%b exp=0100", f); end
        total++; if (l !== 3)       begin bad++; $display("FAIL op7_latency got=%0d exp=3", l); end
`else
        total++; if (d !== 8'h81)   begin bad++; $display("FAIL op7_data got=%h exp=81", d); end
        total++; if (f !== 4'b0101) begin bad++; $display("FAIL op7_flags got=%b exp=0101", f); end
        total++; if (e !== 1'b1)    begin bad++; $display("FAIL op7_op_err got=%b exp=1", e); end
`endif
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_op    = 3'd0;
        bus.in_a     = 8'h00;
        bus.in_b     = 8'h00;
        bus.in_rd    = 3'd0;
        bus.wb_ready = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_xor_stall();
        test_back_to_back();
        test_reset_exec();
        test_shift_ops();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
